// File: rtl/fp_pkg.sv
// Shared widths, constants and the unpacked-float view for the FP add datapath.
package fp_pkg;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned WF_W    = MAN_W + 4;      // hidden, mantissa, G, R, S
    localparam int unsigned SUM_W   = WF_W + 1;       // plus carry
    localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;
    localparam int unsigned LSB_BIT = 3;
    localparam int unsigned G_BIT   = 2;
    localparam int unsigned R_BIT   = 1;
    localparam int unsigned S_BIT   = 0;

    localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_t;
endpackage

// File: rtl/fp_shift_sticky.sv
// Combinational right shifter that folds every shifted-out bit into bit 0.
module fp_shift_sticky
    import fp_pkg::*;
#(
    parameter int unsigned W     = WF_W,
    parameter int unsigned AMT_W = 8
) (
    input  logic [W-1:0]     data_i,
    input  logic [AMT_W-1:0] amt_i,
    output logic [W-1:0]     data_o
);
    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic         lost;

    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        lost      = |data_i;
        if (32'(amt_i) < W) begin
            shifted   = data_i >> amt_i;
            lost_mask = ~({W{1'b1}} << amt_i);
            lost      = |(data_i & lost_mask);
        end
        data_o = {shifted[W-1:1], shifted[0] | lost};
    end
endmodule

// File: rtl/fp_add_datapath.sv
// Datapath for IEEE single add/subtract driven one micro-op strobe at a time
// by an external control unit; returns expDiff/carry/fracResult status.
module fp_add_datapath
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FP_W-1:0]   opA,
    input  logic [FP_W-1:0]   opB,
    input  logic              load,
    input  logic              align_en,
    input  logic              add_en,
    input  logic              norm_en,
    input  logic              round_en,
    input  logic              smallerExpSrc,
    input  logic [7:0]        shiftRightQtt,
    input  logic              shift_src,
    input  logic              normalization_src,
    input  logic              done,
    output logic [EXP_W-1:0]  expDiff,
    output logic              carry,
    output logic [WF_W-1:0]   fracResult,
    output logic [FP_W-1:0]   result,
    output logic              result_valid,
    output logic              overflow,
    output logic              underflow
);
    fp_t a_in, b_in;
    assign a_in = fp_t'(opA);
    assign b_in = fp_t'(opB);

    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, sign_q, sign_d;
    logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_q, exp_d, diff_q, diff_d;
    logic [WF_W-1:0]  frac_a_q, frac_a_d, frac_b_q, frac_b_d;
    logic [SUM_W-1:0] sum_q, sum_d, rnd_q, rnd_d;
    logic             special_q, special_d;
    logic [FP_W-1:0]  special_res_q, special_res_d, result_q, result_d;
    logic             valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d, done_q;

    logic             nan_a, nan_b, inf_a, inf_b, round_up, done_rise;
    logic [WF_W-1:0]  align_in, align_out;
    logic [SUM_W-1:0] norm_val, norm_right, norm_new;
    logic [2:0]       grs;

    assign nan_a = (&a_in.exp) && (|a_in.frac);
    assign nan_b = (&b_in.exp) && (|b_in.frac);
    assign inf_a = (&a_in.exp) && !(|a_in.frac);
    assign inf_b = (&b_in.exp) && !(|b_in.frac);

    assign align_in = smallerExpSrc ? frac_b_q : frac_a_q;
    fp_shift_sticky #(.W(WF_W), .AMT_W(8)) u_align (
        .data_i (align_in),
        .amt_i  (shiftRightQtt),
        .data_o (align_out)
    );

    assign norm_val = normalization_src ? rnd_q : sum_q;
    fp_shift_sticky #(.W(SUM_W), .AMT_W(1)) u_norm (
        .data_i (norm_val),
        .amt_i  (1'b1),
        .data_o (norm_right)
    );

    assign grs       = {sum_q[G_BIT], sum_q[R_BIT], sum_q[S_BIT]};
    assign round_up  = (grs > 3'd4) || ((grs == 3'd4) && sum_q[LSB_BIT]);
    assign done_rise = done && !done_q;

    // Next-state for every register; load wins, then align, add, round, norm.
    always_comb begin
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        sign_d        = sign_q;
        exp_a_d       = exp_a_q;
        exp_b_d       = exp_b_q;
        exp_d         = exp_q;
        diff_d        = diff_q;
        frac_a_d      = frac_a_q;
        frac_b_d      = frac_b_q;
        sum_d         = sum_q;
        rnd_d         = rnd_q;
        special_d     = special_q;
        special_res_d = special_res_q;
        result_d      = result_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        norm_new      = norm_val;
        valid_d       = done_rise;

        if (load) begin
            sign_a_d  = a_in.sign;
            sign_b_d  = b_in.sign;
            exp_a_d   = a_in.exp;
            exp_b_d   = b_in.exp;
            frac_a_d  = {|a_in.exp, a_in.frac, 3'b000};
            frac_b_d  = {|b_in.exp, b_in.frac, 3'b000};
            diff_d    = a_in.exp - b_in.exp;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            special_d = 1'b1;
            if (nan_a || nan_b || (inf_a && inf_b && (a_in.sign != b_in.sign)))
                special_res_d = QNAN;
            else if (inf_a)
                special_res_d = opA;
            else if (inf_b)
                special_res_d = opB;
            else
                special_d = 1'b0;
        end else if (!special_q) begin
            if (align_en) begin
                if (smallerExpSrc) begin
                    frac_b_d = align_out;
                    exp_d    = exp_a_q;
                end else begin
                    frac_a_d = align_out;
                    exp_d    = exp_b_q;
                end
            end else if (add_en) begin
                rnd_d = '0;
                if (sign_a_q == sign_b_q) begin
                    sum_d  = {1'b0, frac_a_q} + {1'b0, frac_b_q};
                    sign_d = sign_a_q;
                end else begin
                    if (frac_a_q >= frac_b_q) begin
                        sum_d  = {1'b0, frac_a_q - frac_b_q};
                        sign_d = sign_a_q;
                    end else begin
                        sum_d  = {1'b0, frac_b_q - frac_a_q};
                        sign_d = sign_b_q;
                    end
                    if (sum_d == '0)
                        sign_d = 1'b0;
                end
            end else if (round_en) begin
                rnd_d = round_up ? sum_q + SUM_W'(8) : sum_q;
            end else if (norm_en) begin
                if (norm_val == '0) begin
                    exp_d = '0;
                end else begin
                    if (shift_src) begin
                        if (exp_q + EXP_W'(1) == EXP_MAX) begin
                            norm_new = '0;
                            exp_d    = EXP_MAX;
                            ovf_d    = 1'b1;
                        end else begin
                            norm_new = norm_right;
                            exp_d    = exp_q + EXP_W'(1);
                        end
                    end else if (exp_q <= EXP_W'(1)) begin
                        norm_new = '0;
                        exp_d    = '0;
                        unf_d    = 1'b1;
                    end else begin
                        norm_new = norm_val << 1;
                        exp_d    = exp_q - EXP_W'(1);
                    end
                    if (normalization_src)
                        rnd_d = norm_new;
                    else
                        sum_d = norm_new;
                end
            end
        end

        if (done_rise)
            result_d = special_q ? special_res_q : {sign_q, exp_q, norm_val[MAN_W+2:LSB_BIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            sign_q        <= 1'b0;
            exp_a_q       <= '0;
            exp_b_q       <= '0;
            exp_q         <= '0;
            diff_q        <= '0;
            frac_a_q      <= '0;
            frac_b_q      <= '0;
            sum_q         <= '0;
            rnd_q         <= '0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
            valid_q       <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            sign_q        <= sign_d;
            exp_a_q       <= exp_a_d;
            exp_b_q       <= exp_b_d;
            exp_q         <= exp_d;
            diff_q        <= diff_d;
            frac_a_q      <= frac_a_d;
            frac_b_q      <= frac_b_d;
            sum_q         <= sum_d;
            rnd_q         <= rnd_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
            result_q      <= result_d;
            valid_q       <= valid_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            done_q        <= done;
        end
    end

    assign expDiff             = diff_q;
    assign {carry, fracResult} = norm_val;
    assign result              = result_q;
    assign result_valid        = valid_q;
    assign overflow            = ovf_q;
    assign underflow           = unf_q;
endmodule

// File: doc/fp_add_datapath.md
Name: fp_add_datapath

Overview:
Datapath responder for the floating-point add control unit. It consumes that unit's control outputs (smallerExpSrc, shiftRightQtt, shift_src, normalization_src, done) and returns its status inputs (expDiff, carry, fracResult). It holds all operand, sum, normalize and round registers for IEEE-754 single-precision add/subtract and publishes the packed result when the control unit signals completion. One micro-operation strobe per step, issued by the control unit.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored mantissa width (working fraction = MAN_W+4: hidden, mantissa, guard, round, sticky)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
opA  in  32  operand A, IEEE single
opB  in  32  operand B, IEEE single
load  in  1  latch operands and compute expDiff
align_en  in  1  align smaller fraction
add_en  in  1  add/subtract aligned fractions
norm_en  in  1  one normalize step
round_en  in  1  round-to-nearest-even step
smallerExpSrc  in  1  0: A has smaller exponent; 1: B smaller or equal
shiftRightQtt  in  8  alignment shift amount
shift_src  in  1  normalize direction: 1 right, 0 left
normalization_src  in  1  normalizer source: 0 sum register, 1 round register
done  in  1  completion from control unit
expDiff  out  8  expA-expB, two's complement, registered
carry  out  1  bit 27 of selected working value
fracResult  out  27  bits 26:0 of selected working value
result  out  32  packed IEEE result
result_valid  out  1  one-cycle pulse when result updates
overflow  out  1  sticky, exponent reached 255
underflow  out  1  sticky, flushed to zero

Behaviour:
- Reset (async, any time including mid-operation): all registers 0. Outputs expDiff, carry, fracResult, result, result_valid, overflow and underflow are 0. done edge detector is cleared.
- Strobe priority when several are high: load > align_en > add_en > round_en > norm_en. Only the winner acts. Each action completes in one clock, and its effect is visible on outputs the next cycle.
- load: latches signs, exponents and fractions. Hidden bit = 1 if exponent != 0, else 0 (denormals treated as zero magnitude). GRS bits = 0. expDiff = expA - expB, truncated to 8 bits. Clears overflow and underflow.
- Special cases at load: a NaN operand, or inf + opposite-sign inf, sets special result 0x7FC00000. A single inf, or same-sign infs, sets special result equal to that inf. When special is set, later strobes are ignored and done publishes the special result.
- align_en: the smaller-exponent fraction is shifted right by shiftRightQtt. Shifted-out bits are ORed into sticky (bit 0). If shiftRightQtt >= 27, the fraction becomes 0 with sticky = OR of the original fraction. Working exponent = larger exponent.
- add_en: equal signs give a 28-bit sum, sign = shared sign. Unequal signs give larger magnitude minus smaller, sign = sign of larger. An exact zero difference gives +0. The result goes to the sum register, and the round register is cleared.
- norm_en acts on the register chosen by normalization_src and writes it back.
  - shift_src=1: shift right 1, bit 0 ORed into sticky, exponent +1.
  - shift_src=0: shift left 1, exponent -1.
  - Zero fraction: no shift; exponent forced to 0.
  - Exponent reaching 255: result becomes inf of the current sign, overflow=1.
  - Left shift with exponent 1: flush to signed zero, underflow=1.
- round_en: reads the sum register. With LSB = bit 3 and G,R,S = bits 2:0, round up when GRS > 4, or GRS == 4 and LSB == 1. Round up adds 8. Output is 28 bits to the round register, and carry may set.
- Status outputs: {carry, fracResult} reflect the register selected by normalization_src every cycle.
- done: rising edge (0 to 1) latches result = {sign, exp, sel[25:3]} (or the special result) and pulses result_valid for one cycle. Holding done high does not re-pulse.

Decomposition:
- Shared package fp_pkg:
  - EXP_W and MAN_W
  - QNAN = 0x7FC00000
  - EXP_MAX = 255
  - GRS bit indices
  - unpacked-float typedef {sign, exp, frac}
- One sub-module: fp_shift_sticky (combinational right shifter with sticky OR), used by align and right-normalize.

Test Plan:
- 0x3F800000 + 0x3F800000: load, align(0), add -> expDiff=0, carry=1. One right norm, round, done -> result 0x40000000, result_valid pulses once.
- 0x3FC00000 + 0xBF800000 -> after add fracResult[26]=0. One left norm -> result 0x3F000000.
- 0x3F800000 + 0x30800000: expDiff=30, shiftRightQtt=30 -> sticky only, no round-up -> 0x3F800000.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1.
- Round-to-even tie: 0x3F800000 + 0x33800000 -> 0x3F800000. Adding 0x34000000 -> 0x3F800001.
- rst asserted mid-normalize -> all outputs 0 immediately. No result_valid until the next done edge after a fresh load.
